// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multi-cycle RISC-V control path:
//   - ALU opcode encodings driven on alu_op
//   - major opcode and funct3/funct7 values recognised by the controller
//   - select encodings for alu_src_a, alu_src_b and result_src
//   - controller state enum and the bundled control-output struct
// ---------------------------------------------------------------------------
package riscv_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 / funct7 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // Operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALUWB    = 4'd4,
    S_MEMADR   = 4'd5,
    S_MEMREAD  = 4'd6,
    S_MEMWB    = 4'd7,
    S_MEMWRITE = 4'd8,
    S_BEQ      = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_e;

  // All per-state control outputs, so they can be cleared in one assignment
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/riscv_mc_control_if.sv
// ---------------------------------------------------------------------------
// riscv_mc_control_if
// Bundle between the control FSM and the datapath/memory.
//   Datapath -> control : instr[31:0], zero, mem_ready
//   Control -> datapath : mem_req, mem_we, adr_src, ir_write, pc_write,
//                         reg_write, alu_src_a[1:0], alu_src_b[1:0],
//                         result_src[1:0], alu_op[3:0], illegal,
//                         retired[CNT_W-1:0]
// master = control FSM side, slave = datapath side.
// ---------------------------------------------------------------------------
interface riscv_mc_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       result_src;
  logic [3:0]       alu_op;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_op, illegal, retired
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_op, illegal, retired
  );
endinterface

// File: rtl/riscv_alu_dec.sv
// ---------------------------------------------------------------------------
// riscv_alu_dec
// Combinational funct3/funct7 decode for OP and OP-IMM instructions.
//   i_is_rtype : 1 = register-register (funct7 checked), 0 = immediate form
//   i_funct3   : instr[14:12]
//   i_funct7   : instr[31:25]
//   o_alu_op   : ALU operation for the execute step
//   o_legal    : 1 when the funct combination is supported
// ---------------------------------------------------------------------------
module riscv_alu_dec
  import riscv_pkg::*;
(
  input  logic       i_is_rtype,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_op,
  output logic       o_legal
);

  logic w_f3_ok;
  logic w_f7_ok;

  always_comb begin
    o_alu_op = ALU_ADD;
    w_f3_ok  = 1'b1;
    case (i_funct3)
      // funct7[5] only selects subtract for the register form; for addi the
      // upper bits are immediate and must be ignored.
      F3_ADD:  o_alu_op = (i_is_rtype && i_funct7[5]) ? ALU_SUB : ALU_ADD;
      F3_XOR:  o_alu_op = ALU_XOR;
      F3_OR:   o_alu_op = ALU_OR;
      F3_AND:  o_alu_op = ALU_AND;
      default: w_f3_ok  = 1'b0;
    endcase
  end

  // Register form: funct7 must be all-zero, except 0100000 which is only sub.
  assign w_f7_ok = !i_is_rtype
                || (i_funct7 == F7_BASE)
                || ((i_funct7 == F7_ALT) && (i_funct3 == F3_ADD));

  assign o_legal = w_f3_ok && w_f7_ok;

endmodule

// File: rtl/riscv_mc_control.sv
// ---------------------------------------------------------------------------
// riscv_mc_control
// Multi-cycle main control FSM: fetch, decode, execute, memory, writeback.
//   clk   : system clock
//   reset : synchronous, active-high; forces all outputs to 0 while high
//   bus   : riscv_mc_control_if.master (instr/zero/mem_ready in, control out)
// Outputs are combinational from the state, plus mem_ready in the memory
// states and zero/instr in BEQ and the execute states.
// ---------------------------------------------------------------------------
module riscv_mc_control
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_mc_control_if.master   bus
);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  ctrl_t            w_ctl;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [3:0] w_dec_op;
  logic       w_dec_legal;

  assign w_opcode = bus.instr[6:0];
  assign w_funct3 = bus.instr[14:12];
  assign w_funct7 = bus.instr[31:25];

  // One decoder serves both the DECODE legality check and the execute op.
  riscv_alu_dec u_alu_dec (
    .i_is_rtype (w_opcode == OP_R),
    .i_funct3   (w_funct3),
    .i_funct7   (w_funct7),
    .o_alu_op   (w_dec_op),
    .o_legal    (w_dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    w_ctl        = '0;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.adr_src = 1'b0;
        if (bus.mem_ready) begin
          w_ctl.ir_write   = 1'b1;
          w_ctl.alu_src_a  = SRCA_PC;
          w_ctl.alu_src_b  = SRCB_FOUR;
          w_ctl.alu_op     = ALU_ADD;
          w_ctl.result_src = RES_ALU;
          w_ctl.pc_write   = 1'b1;
          w_state_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        w_ctl.alu_src_a = SRCA_OLDPC;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALU_ADD;
        case (w_opcode)
          OP_R:      w_state_next = w_dec_legal ? S_EXEC_R : S_ILLEGAL;
          OP_I:      w_state_next = w_dec_legal ? S_EXEC_I : S_ILLEGAL;
          OP_LOAD,
          OP_STORE:  w_state_next = (w_funct3 == F3_WORD) ? S_MEMADR : S_ILLEGAL;
          OP_BRANCH: w_state_next = (w_funct3 == F3_BEQ) ? S_BEQ : S_ILLEGAL;
          default:   w_state_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        w_ctl.alu_src_a = SRCA_RS1;
        w_ctl.alu_src_b = SRCB_RS2;
        w_ctl.alu_op    = w_dec_op;
        w_state_next    = S_ALUWB;
      end
      S_EXEC_I: begin
        w_ctl.alu_src_a = SRCA_RS1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = w_dec_op;
        w_state_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_ctl.result_src = RES_ALUOUT;
        w_ctl.reg_write  = 1'b1;
        w_retire         = 1'b1;
        w_state_next     = S_FETCH;
      end
      S_MEMADR: begin
        w_ctl.alu_src_a = SRCA_RS1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALU_ADD;
        w_state_next    = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.adr_src = 1'b1;
        if (bus.mem_ready) begin
          w_state_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_ctl.result_src = RES_MEM;
        w_ctl.reg_write  = 1'b1;
        w_retire         = 1'b1;
        w_state_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.mem_we  = 1'b1;
        w_ctl.adr_src = 1'b1;
        if (bus.mem_ready) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_BEQ: begin
        // PC takes the target held in ALUOut only when rs1 - rs2 == 0.
        w_ctl.alu_src_a  = SRCA_RS1;
        w_ctl.alu_src_b  = SRCB_RS2;
        w_ctl.alu_op     = ALU_SUB;
        w_ctl.result_src = RES_ALUOUT;
        w_ctl.pc_write   = bus.zero;
        w_retire         = 1'b1;
        w_state_next     = S_FETCH;
      end
      S_ILLEGAL: begin
        w_ctl.illegal = 1'b1;
        w_state_next  = S_FETCH;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Reset overrides every output combinationally, so a pending memory
  // request is dropped in the same cycle reset is seen.
  ctrl_t w_out;
  assign w_out = reset ? '0 : w_ctl;

  assign bus.mem_req    = w_out.mem_req;
  assign bus.mem_we     = w_out.mem_we;
  assign bus.adr_src    = w_out.adr_src;
  assign bus.ir_write   = w_out.ir_write;
  assign bus.pc_write   = w_out.pc_write;
  assign bus.reg_write  = w_out.reg_write;
  assign bus.alu_src_a  = w_out.alu_src_a;
  assign bus.alu_src_b  = w_out.alu_src_b;
  assign bus.result_src = w_out.result_src;
  assign bus.alu_op     = w_out.alu_op;
  assign bus.illegal    = w_out.illegal;
  assign bus.retired    = reset ? '0 : r_retired;

endmodule

// File: tb/tb_riscv_mc_control.sv
// ---------------------------------------------------------------------------
// tb_riscv_mc_control
// Directed, table-driven bench for riscv_mc_control: one table row per clock
// cycle with inputs and hand-computed control outputs, followed by a short
// hand-written sequence for reset during a memory wait.
// ---------------------------------------------------------------------------
module tb_riscv_mc_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [3:0] op;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        mr;
    exp_t        exp;
    logic [31:0] ret;
  } vec_t;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  vec_t vq[$];

  riscv_mc_control_if #(.CNT_W(32)) bus ();

  riscv_mc_control #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(bit req, bit we, bit adr, bit irw, bit pcw, bit rw,
                              bit [1:0] sa, bit [1:0] sb, bit [1:0] rs,
                              bit [3:0] op, bit ill);
    exp_t e;
    e.mem_req = req; e.mem_we = we; e.adr_src = adr; e.ir_write = irw;
    e.pc_write = pcw; e.reg_write = rw; e.sa = sa; e.sb = sb; e.rs = rs;
    e.op = op; e.ill = ill;
    return e;
  endfunction

  task automatic add(input logic [31:0] instr, input logic zero, input logic mr,
                     input exp_t e, input logic [31:0] ret);
    vec_t v;
    v.instr = instr; v.zero = zero; v.mr = mr; v.exp = e; v.ret = ret;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input exp_t e, input logic [31:0] ret);
    exp_t got;
    got.mem_req = bus.mem_req;    got.mem_we = bus.mem_we;
    got.adr_src = bus.adr_src;    got.ir_write = bus.ir_write;
    got.pc_write = bus.pc_write;  got.reg_write = bus.reg_write;
    got.sa = bus.alu_src_a;       got.sb = bus.alu_src_b;
    got.rs = bus.result_src;      got.op = bus.alu_op;
    got.ill = bus.illegal;
    n_total++;
    if (got === e && bus.retired === ret) begin
      n_pass++;
      $display("ok   %s ctl=%05h retired=%0d", name, got, bus.retired);
    end else begin
      $display("FAIL %s ctl=%05h retired=%0d, expected ctl=%05h retired=%0d",
               name, got, bus.retired, e, ret);
    end
  endtask

  // Drive one cycle's inputs just after posedge, check at negedge.
  task automatic step(input string name, input logic [31:0] instr, input logic zero,
                      input logic mr, input exp_t e, input logic [31:0] ret);
    bus.instr = instr; bus.zero = zero; bus.mem_ready = mr;
    @(negedge clk);
    check(name, e, ret);
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
  localparam logic [31:0] I_LW   = 32'h0040A283;
  localparam logic [31:0] I_SW   = 32'h0050A423;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_XORI = 32'hFFF0C093;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  initial begin
    exp_t e_zero, e_fgo, e_fhold, e_dec, e_exr_add, e_exr_sub, e_exi_xor,
          e_aluwb, e_ill, e_madr, e_mrd, e_mwb, e_mwr, e_beq_t, e_beq_n;

    e_zero    = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0000,0);
    e_fgo     = mk(1,0,0,1,1,0,2'b00,2'b10,2'b10,4'b0010,0);
    e_fhold   = mk(1,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0000,0);
    e_dec     = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,4'b0010,0);
    e_exr_add = mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,4'b0010,0);
    e_exr_sub = mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,4'b0110,0);
    e_exi_xor = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,4'b0011,0);
    e_aluwb   = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,4'b0000,0);
    e_ill     = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0000,1);
    e_madr    = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,4'b0010,0);
    e_mrd     = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,4'b0000,0);
    e_mwb     = mk(0,0,0,0,0,1,2'b00,2'b00,2'b01,4'b0000,0);
    e_mwr     = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,4'b0000,0);
    e_beq_t   = mk(0,0,0,0,1,0,2'b10,2'b00,2'b00,4'b0110,0);
    e_beq_n   = mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,4'b0110,0);

    // add: FETCH DECODE EXEC_R ALUWB
    add(I_ADD, 0, 1, e_fgo, 0);      add(I_ADD, 0, 1, e_dec, 0);
    add(I_ADD, 0, 1, e_exr_add, 0);  add(I_ADD, 0, 1, e_aluwb, 0);
    // sub
    add(I_SUB, 0, 1, e_fgo, 1);      add(I_SUB, 0, 1, e_dec, 1);
    add(I_SUB, 0, 1, e_exr_sub, 1);  add(I_SUB, 0, 1, e_aluwb, 1);
    // unsupported opcode: 3 cycles, no retire
    add(I_BAD, 0, 1, e_fgo, 2);      add(I_BAD, 0, 1, e_dec, 2);
    add(I_BAD, 0, 1, e_ill, 2);
    // lw with two wait cycles in MEMREAD: 7 cycles
    add(I_LW, 0, 1, e_fgo, 2);       add(I_LW, 0, 1, e_dec, 2);
    add(I_LW, 0, 1, e_madr, 2);      add(I_LW, 0, 0, e_mrd, 2);
    add(I_LW, 0, 0, e_mrd, 2);       add(I_LW, 0, 1, e_mrd, 2);
    add(I_LW, 0, 1, e_mwb, 2);
    // sw: 4 cycles
    add(I_SW, 0, 1, e_fgo, 3);       add(I_SW, 0, 1, e_dec, 3);
    add(I_SW, 0, 1, e_madr, 3);      add(I_SW, 0, 1, e_mwr, 3);
    // beq taken then not taken
    add(I_BEQ, 1, 1, e_fgo, 4);      add(I_BEQ, 1, 1, e_dec, 4);
    add(I_BEQ, 1, 1, e_beq_t, 4);
    add(I_BEQ, 0, 1, e_fgo, 5);      add(I_BEQ, 0, 1, e_dec, 5);
    add(I_BEQ, 0, 1, e_beq_n, 5);
    // xori with nonzero upper immediate bits
    add(I_XORI, 0, 1, e_fgo, 6);     add(I_XORI, 0, 1, e_dec, 6);
    add(I_XORI, 0, 1, e_exi_xor, 6); add(I_XORI, 0, 1, e_aluwb, 6);
    // R-type with unsupported funct7
    add(I_MUL, 0, 1, e_fgo, 7);      add(I_MUL, 0, 1, e_dec, 7);
    add(I_MUL, 0, 1, e_ill, 7);

    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    bus.instr = I_ADD; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs", e_zero, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vq[i]) begin
      step($sformatf("vec%0d", i), vq[i].instr, vq[i].zero, vq[i].mr,
           vq[i].exp, vq[i].ret);
    end

    // Reset during a MEMREAD wait, then recovery.
    step("rst_seq_fetch",   I_LW, 0, 1, e_fgo, 7);
    step("rst_seq_decode",  I_LW, 0, 1, e_dec, 7);
    step("rst_seq_memadr",  I_LW, 0, 1, e_madr, 7);
    step("rst_seq_memwait", I_LW, 0, 0, e_mrd, 7);
    reset = 1'b1;
    step("rst_mid_memread", I_LW, 0, 0, e_zero, 0);
    reset = 1'b0;
    step("post_rst_fetch_hold",  I_LW, 0, 0, e_fhold, 0);
    step("post_rst_fetch_hold2", I_LW, 0, 0, e_fhold, 0);
    step("post_rst_fetch_go",    I_LW, 0, 1, e_fgo, 0);
    step("post_rst_decode",      I_LW, 0, 1, e_dec, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
